// File: rtl/tlut_temporal_mac_pkg.sv
// tlut_pkg: shared state type and default operand widths for the temporal-LUT multiplier
package tlut_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} tlut_mac_state_t;
  localparam int A_WIDTH_DEF = 2;
  localparam int B_WIDTH_DEF = 8;
endpackage

// File: rtl/tlut_temporal_mac_down_counter.sv
// tlut_down_counter: loadable down counter with a cnt==1 flag
// ports: clk, rst_n (async, active-low), load/load_val, dec in; cnt, last out
module tlut_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         last
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign last = cnt == W'(1);
endmodule

// File: rtl/tlut_temporal_mac.sv
// tlut_temporal_mac: forms a*b by adding b once per clock for a cycles, valid/ready in and out
// ports: clk, rst_n (async, active-low); in_valid/in_ready, a_in, b_in; out_valid/out_ready, product
// option: TLUT_MAC_OVERLAP_EN lets a new operand pair be accepted in the same cycle the product leaves
module tlut_temporal_mac
  import tlut_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         a_in,
  input  logic [B_WIDTH-1:0]         b_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  tlut_mac_state_t state, state_nx, load_st;
  logic [B_WIDTH-1:0] b_q;
  logic [P_WIDTH-1:0] acc;
  logic [A_WIDTH-1:0] cnt;
  logic last, accept, run;
  assign accept = in_valid && in_ready;
  assign run = state == RUN;
  assign load_st = (a_in == '0) ? DONE : RUN;
  assign out_valid = state == DONE;
  assign product = acc;
  tlut_down_counter #(.W(A_WIDTH)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (a_in),
    .dec      (run && cnt != '0),
    .cnt      (cnt),
    .last     (last)
  );
  always_comb begin
`ifdef TLUT_MAC_OVERLAP_EN
    in_ready = (state == IDLE) || (state == DONE && out_ready);
`else
    in_ready = state == IDLE;
`endif
    state_nx = accept ? load_st
             : (run && last) ? DONE
             : (out_valid && out_ready) ? IDLE
             : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      b_q <= '0;
    end else if (accept) begin
      acc <= '0;
      b_q <= b_in;
    end else if (run) acc <= acc + P_WIDTH'(b_q);
endmodule

// File: tb/tb_tlut_temporal_mac.sv
// tb_tlut_temporal_mac: scoreboard bench for tlut_temporal_mac (A_WIDTH=2, B_WIDTH=8)
module tb_tlut_temporal_mac;
  typedef struct {int p; int a; int c;} exp_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [1:0] a_in = 0;
  logic [7:0] b_in = 0;
  logic [9:0] product;
  exp_t exp_q[$];
  exp_t e;
  int cyc = 0, bp_mode = 0, n_checks = 0, n_fail = 0, last_acc = 0, prev_acc = 0;
  bit active = 0;
  logic [9:0] held;
  tlut_temporal_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && out_valid) begin
      if (!active) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("product", 32'(product), e.p);
          chk("latency", cyc - e.c, e.a + 1);
          held = product;
          active = 1;
        end
      end else chk("stall_hold", 32'(product), 32'(held));
      if (out_ready) active = 0;
    end
  task automatic send(input int a, input int b);
    bit ok = 0;
    in_valid = 1;
    a_in = a[1:0];
    b_in = b[7:0];
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{a * b, a, cyc});
        prev_acc = last_acc;
        last_acc = cyc;
        ok = 1;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = exp_q.size() == 0 && !out_valid;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_product", 32'(product), 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(in_ready), 1);
    send(0, 255);
    drain();
    send(3, 255);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("run_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
`ifdef TLUT_MAC_OVERLAP_EN
    chk("done_in_ready", 32'(in_ready), 1);
`else
    chk("done_in_ready", 32'(in_ready), 0);
`endif
    drain();
    bp_mode = 1;
    send(2, 10);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_product", 32'(product), 20);
      if (i < 4) @(negedge clk);
    end
    bp_mode = 0;
    @(negedge clk);
    chk("release_valid", 32'(out_valid), 1);
    @(negedge clk);
    chk("after_release_valid", 32'(out_valid), 0);
    drain();
    send(1, 7);
    send(2, 9);
`ifdef TLUT_MAC_OVERLAP_EN
    chk("b2b_gap", last_acc - prev_acc, 2);
`else
    chk("b2b_gap", last_acc - prev_acc, 3);
`endif
    drain();
    send(3, 200);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrun_rst_in_ready", 32'(in_ready), 1);
    chk("midrun_rst_out_valid", 32'(out_valid), 0);
    chk("midrun_rst_product", 32'(product), 0);
    exp_q.delete();
    active = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    bp_mode = 2;
    repeat (30) send(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    drain();
    chk("queue_empty", exp_q.size(), 0);
    bp_mode = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
